// File: rtl/pipelined_ram.sv
// pipelined_ram: byte-masked word RAM with a fixed-latency, fully pipelined response path.
// Define PIPELINED_RAM_CLEAR_EN to zero every word after each reset before requests are accepted.
module pipelined_ram #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 16384,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memReq,
  output logic                    memReady,
  input  logic [31:0]             memAddress,
  input  logic                    memWrite,
  input  logic [DATA_WIDTH-1:0]   memWriteData,
  input  logic [DATA_WIDTH/8-1:0] byteMask,
  output logic                    memValid,
  output logic [DATA_WIDTH-1:0]   memReadData,
  output logic                    memError
);

  localparam int          NB        = DATA_WIDTH / 8;
  localparam int          BYTE_BITS = $clog2(NB);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] LSB_MASK  = 32'(NB - 1);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready_q;
  logic                  ready_d;
  logic [32:0]           offset_s;
  logic [31:0]           word_off_s;
  logic [AW-1:0]         idx_s;
  logic                  bad_s;
  logic                  accept_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic [AW-1:0]         wr_idx_s;
  logic [NB-1:0]         wr_be_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  logic [READ_LATENCY-1:0]                 vld_q;
  logic [READ_LATENCY-1:0]                 vld_d;
  logic [READ_LATENCY-1:0]                 err_q;
  logic [READ_LATENCY-1:0]                 err_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_d;

  // The 33-bit difference keeps the borrow, so addresses below BASE_ADDR are caught as bad.
  always_comb begin
    offset_s   = {1'b0, memAddress} - {1'b0, BASE_ADDR};
    word_off_s = offset_s[31:0] >> BYTE_BITS;
    idx_s      = word_off_s[AW-1:0];
    bad_s      = offset_s[32]
               | ((offset_s[31:0] & LSB_MASK) != 32'd0)
               | (word_off_s >= DEPTH_W);
    accept_s   = memReq & memReady;
    wr_en_s    = accept_s & memWrite & ~bad_s;
    rd_word_s  = mem_q[idx_s];
  end

`ifdef PIPELINED_RAM_CLEAR_EN
  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_CLEAR = 2'd1;
  localparam logic [1:0]    ST_RUN   = 2'd2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [AW-1:0] clr_idx_q;
  logic [AW-1:0] clr_idx_d;
  logic          clr_we_s;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_ONE;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign clr_we_s = reset & (state_q == ST_CLEAR);

  // The sweep owns the write port while it runs; memReady is low so no request competes.
  always_comb begin
    if (clr_we_s) begin
      wr_idx_s  = clr_idx_q;
      wr_be_s   = '1;
      wr_data_s = '0;
    end else begin
      wr_idx_s  = idx_s;
      wr_be_s   = wr_en_s ? byteMask : '0;
      wr_data_s = memWriteData;
    end
  end
`else
  always_comb begin
    ready_d   = 1'b1;
    wr_idx_s  = idx_s;
    wr_be_s   = wr_en_s ? byteMask : '0;
    wr_data_s = memWriteData;
  end
`endif

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be_s[b]) begin
        mem_q[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
      end
    end
  end

  // Stage 0 captures the response at acceptance; data is forced to 0 unless it is a good read.
  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    dat_d    = '0;
    vld_d[0] = accept_s;
    err_d[0] = accept_s & bad_s;
    dat_d[0] = (accept_s & ~memWrite & ~bad_s) ? rd_word_s : '0;
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      err_d[s] = err_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      dat_q   <= '0;
    end else begin
      ready_q <= ready_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign memReady    = ready_q & reset;
  assign memValid    = vld_q[READ_LATENCY-1];
  assign memError    = err_q[READ_LATENCY-1];
  assign memReadData = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_pipelined_ram.sv
// Scoreboard bench for pipelined_ram: one instance at READ_LATENCY=1 and one at 3 share the stimulus.
`timescale 1ns/1ps
module tb_pipelined_ram;

  localparam int DEPTH = 16384;
`ifdef PIPELINED_RAM_CLEAR_EN
  localparam int EXP_WAIT = DEPTH;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  byte_mask;
  logic        rdy1, vld1, err1;
  logic [31:0] rd1;
  logic        rdy3, vld3, err3;
  logic [31:0] rd3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_ram #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .memReq(mem_req), .memReady(rdy1), .memAddress(mem_addr),
    .memWrite(mem_write), .memWriteData(mem_wdata), .byteMask(byte_mask),
    .memValid(vld1), .memReadData(rd1), .memError(err1));

  pipelined_ram #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .memReq(mem_req), .memReady(rdy3), .memAddress(mem_addr),
    .memWrite(mem_write), .memWriteData(mem_wdata), .byteMask(byte_mask),
    .memValid(vld3), .memReadData(rd3), .memError(err3));

  // Monitor: pops one expectation per memValid and checks idle outputs stay at zero.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vld1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid_lat1 cyc=%0d data=%h err=%b", cyc, rd1, err1);
        end else begin
          e = q1.pop_front();
          if (e.due != cyc || rd1 !== e.data || err1 !== e.err) begin
            errors++;
            $display("FAIL resp_lat1 got cyc=%0d data=%h err=%b expected cyc=%0d data=%h err=%b",
                     cyc, rd1, err1, e.due, e.data, e.err);
          end
        end
      end else begin
        checks++;
        if (rd1 !== 32'h0 || err1 !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero_lat1 cyc=%0d data=%h err=%b expected 0", cyc, rd1, err1);
        end
        if (q1.size() != 0 && q1[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_lat1 cyc=%0d expected valid at cyc=%0d", cyc, q1[0].due);
          e = q1.pop_front();
        end
      end
      if (vld3) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid_lat3 cyc=%0d data=%h err=%b", cyc, rd3, err3);
        end else begin
          e = q3.pop_front();
          if (e.due != cyc || rd3 !== e.data || err3 !== e.err) begin
            errors++;
            $display("FAIL resp_lat3 got cyc=%0d data=%h err=%b expected cyc=%0d data=%h err=%b",
                     cyc, rd3, err3, e.due, e.data, e.err);
          end
        end
      end else begin
        checks++;
        if (rd3 !== 32'h0 || err3 !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero_lat3 cyc=%0d data=%h err=%b expected 0", cyc, rd3, err3);
        end
        if (q3.size() != 0 && q3[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_lat3 cyc=%0d expected valid at cyc=%0d", cyc, q3[0].due);
          e = q3.pop_front();
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [31:0] exp_d, input logic exp_e,
                       input logic push3);
    exp_t e;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_issue cyc=%0d got %b/%b expected 1/1", cyc, rdy1, rdy3);
    end
    mem_req   = 1'b1;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = data;
    byte_mask = mask;
    e.data = exp_d;
    e.err  = exp_e;
    e.due  = cyc + 1;
    q1.push_back(e);
    if (push3) begin
      e.due = cyc + 3;
      q3.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    byte_mask = 4'h0;
  endtask

  task automatic release_reset();
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < DEPTH + 8; i++) begin
      @(negedge clk);
      if (rdy1 === 1'b1 && rdy3 === 1'b1) break;
      n++;
    end
    checks++;
    if (n != EXP_WAIT) begin
      errors++;
      $display("FAIL ready_after_reset got %0d not-ready cycles expected %0d", n, EXP_WAIT);
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    byte_mask = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy1, vld1, err1, rdy3, vld3, err3} !== 6'b0 || rd1 !== 32'h0 || rd3 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h expected all 0",
               rdy1, rdy3, vld1, vld3, err1, err3, rd1, rd3);
    end
    mon_en = 1'b1;
    release_reset();

    // Full write then immediate read-back
    issue(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Partial byte-mask merge; read with mask 0 still returns the whole word
    issue(1'b1, 32'h0000_8000, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_8000, 32'hAABB_CCDD, 4'h6, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_8000, 32'h0,         4'h0, 32'h12BB_CC78, 1'b0, 1'b1);
    idle_cycle();
    // Preload four words, then four back-to-back reads
    issue(1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0014, 32'h2222_2222, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0018, 32'h3333_3333, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_001C, 32'h4444_4444, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h2222_2222, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0018, 32'h0, 4'hF, 32'h3333_3333, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_001C, 32'h0, 4'hF, 32'h4444_4444, 1'b0, 1'b1);
    // Misaligned write and out-of-range read are errors and leave word 0 alone
    issue(1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h0001_0000, 32'h0,         4'hF, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Last word in range
    issue(1'b1, 32'h0000_FFFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_FFFC, 32'h0,         4'hF, 32'h5A5A_5A5A, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    idle_cycle();

    // Two reads in flight when reset hits: the latency-3 copy must never answer them
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    mem_req = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset got %b/%b expected 0/0", rdy1, rdy3);
    end
    repeat (4) @(negedge clk);
    release_reset();

`ifdef PIPELINED_RAM_CLEAR_EN
    issue(1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_8000, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
`else
    issue(1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_8000, 32'h0, 4'hF, 32'h12BB_CC78, 1'b0, 1'b1);
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b0, 1'b1);
`endif
    idle_cycle();

    for (int i = 0; i < 20; i++) begin
      if (q1.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d outstanding expected 0/0", q1.size(), q3.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_ram.md
PIPELINED_RAM -- requirements
Module: pipelined_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; multiple of 8, 8..128.
REQ-002 SHALL have parameter DEPTH, default 16384: words stored; power of two, >= 16.
REQ-003 SHALL have parameter READ_LATENCY, default 1: cycles from request acceptance to response; 1..4.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have reset  input  1  synchronous active-low reset.
REQ-007 SHALL have memReq  input  1  request valid.
REQ-008 SHALL have memReady  output  1  request can be accepted this cycle.
REQ-009 SHALL have memAddress  input  32  byte address.
REQ-010 SHALL have memWrite  input  1  1 = write, 0 = read.
REQ-011 SHALL have memWriteData  input  DATA_WIDTH  write data.
REQ-012 SHALL have byteMask  input  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
REQ-013 SHALL have memValid  output  1  one-cycle response strobe.
REQ-014 SHALL have memReadData  output  DATA_WIDTH  response data; valid only with memValid.
REQ-015 SHALL have memError  output  1  response error flag; valid only with memValid.

Function
REQ-016 SHALL accept a request on a rising edge where memReq=1 and memReady=1; otherwise inputs are ignored.
REQ-017 SHALL compute word index = (memAddress - BASE_ADDR) >> log2(DATA_WIDTH/8).
REQ-018 SHALL flag a request as bad when low log2(DATA_WIDTH/8) address bits are nonzero or index >= DEPTH (including addresses below BASE_ADDR).
REQ-019 SHALL, on an accepted good write, update only bytes with byteMask set, at the accepting edge; byteMask=0 modifies nothing but still responds.
REQ-020 SHALL, on an accepted good read, return the full word regardless of byteMask.
REQ-021 SHALL never modify memory for a bad request.
REQ-022 SHALL produce exactly one memValid pulse exactly READ_LATENCY cycles after each accepted request, in acceptance order.
REQ-023 SHALL drive memReadData = stored word for good reads, 0 for writes and bad requests; memError = 1 only for bad requests.
REQ-024 SHALL accept one request per cycle back-to-back (fully pipelined); no response backpressure.
REQ-025 SHALL return the written data for a read accepted in any cycle after the write to the same word was accepted (read-after-write ordering).
REQ-026 SHALL hold memReadData and memError at 0 in cycles where memValid=0.
REQ-027 SHALL hold memReady=1 at all times outside the clear sweep (REQ-032).

Reset
REQ-028 SHALL, while reset=0 at a rising edge, clear memValid, memError, memReadData to 0 and discard all in-flight responses.
REQ-029 SHALL drive memReady=0 while reset=0.
REQ-030 SHALL not alter memory contents during reset except via REQ-032.
REQ-031 SHALL, on reset asserted mid-pipeline, emit no response for requests accepted before reset.

Configuration
REQ-032 SHALL, with macro PIPELINED_RAM_CLEAR_EN defined, enter state CLEAR on the first edge after reset deasserts, write 0 to one word per cycle from index 0 to DEPTH-1, hold memReady=0 throughout, then enter state RUN with memReady=1 on the cycle after the last word is written (DEPTH cycles in CLEAR).
REQ-033 SHALL, with PIPELINED_RAM_CLEAR_EN defined, restart the sweep from index 0 if reset asserts during CLEAR.
REQ-034 SHALL, without PIPELINED_RAM_CLEAR_EN, omit the sweep counter and FSM, assert memReady=1 from the first edge after reset deasserts, and leave unwritten contents undefined.

Verification
REQ-035 SHALL cover: defaults, write 32'hDEAD_BEEF mask 4'b1111 to 0x0, read 0x0 next cycle -> memValid 1 cycle later, memReadData=32'hDEAD_BEEF, memError=0.
REQ-036 SHALL cover: write 32'h1234_5678 mask 4'b1111 then 32'hAABB_CCDD mask 4'b0110 to 0x8000, read -> 32'h12BB_CC78.
REQ-037 SHALL cover: READ_LATENCY=3, four back-to-back reads of distinct preloaded words -> four consecutive memValid pulses starting 3 cycles after first accept, correct order.
REQ-038 SHALL cover: write to 0x0000_0002 and read of 0x0001_0000 (DEPTH=16384) -> memError=1, memReadData=0, word 0 unchanged.
REQ-039 SHALL cover: reset asserted with two reads in flight -> no memValid for them; with PIPELINED_RAM_CLEAR_EN, memReady=0 for exactly DEPTH cycles after release and every read afterward returns 0.
